tx_sequencer_1553: RTL and testbench
====================================

Name: tx_sequencer_1553

Overview:
- Transmit-side controller between the 18-bit transmit BRAM FIFO and the 1553 encoder.
- Pops entries {csw, dw, dword[15:0]} from the FIFO and presents each to the encoder as a one-cycle load strobe.
- Tracks encoder busy, enforces the inter-message gap before every command/status word, and bounds data words per message.
- Flags malformed entries and encoder stalls.

Parameters:
- GAP_CYCLES, 8, minimum enc_clk cycles from end of the previous word to loading a csw word (4 us at 2 MHz).
- BUSY_TIMEOUT, 16, enc_clk cycles allowed between a load strobe and tx_busy rising.
- MAX_DW, 32, maximum dw words following one csw word.

Ports:
- enc_clk  in  1  2 MHz encoder clock; the only clock.
- reset  in  1  Synchronous reset, active-high.
- enable  in  1  Sequencer run enable.
- fifo_empty  in  1  FIFO EMPTY flag.
- fifo_do  in  18  FIFO read data: [17]=csw, [16]=dw, [15:0]=dword.
- fifo_rd_en  out  1  One-cycle FIFO read strobe.
- tx_busy  in  1  Encoder busy.
- tx_dword  out  16  Word to encoder; held between loads.
- tx_csw  out  1  One-cycle load strobe, command/status sync.
- tx_dw  out  1  One-cycle load strobe, data sync.
- word_cnt  out  6  dw words sent in current message.
- fmt_err  out  1  One-cycle pulse: entry dropped (neither csw nor dw set, or dw overflow).
- timeout_err  out  1  One-cycle pulse: encoder never went busy.
- seq_active  out  1  High whenever state != IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, gap counter saturated at GAP_CYCLES (first csw is not delayed).
- Reset mid-operation: returns to IDLE next edge. Any entry already popped is discarded. Strobes never stretch across reset.
- States: IDLE, READ, CAPTURE, GAP_WAIT, LOAD, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Exit when enable=1 && fifo_empty=0 && tx_busy=0 → READ.
  - Gap counter increments, saturating at GAP_CYCLES.
- READ: fifo_rd_en=1 for exactly this cycle → CAPTURE. fifo_do is valid on the following cycle.
- CAPTURE: latch fifo_do, then decode:
  - csw=1 (dw ignored, csw has priority): if gap counter >= GAP_CYCLES → LOAD, else → GAP_WAIT. word_cnt cleared to 0 at LOAD.
  - csw=0, dw=1, word_cnt < MAX_DW → LOAD; no gap required.
  - csw=0, dw=1, word_cnt == MAX_DW → pulse fmt_err, drop entry → IDLE.
  - csw=0, dw=0 → pulse fmt_err, drop entry → IDLE.
- GAP_WAIT: gap counter keeps incrementing; on reaching GAP_CYCLES → LOAD.
- LOAD:
  - tx_dword updated with the latched data.
  - Exactly one of tx_csw/tx_dw high for this one cycle.
  - Timeout counter cleared → WAIT_BUSY.
  - dw loads increment word_cnt.
- WAIT_BUSY:
  - tx_busy=1 → WAIT_DONE.
  - Timeout counter reaching BUSY_TIMEOUT with tx_busy still 0 → timeout_err pulse, gap counter cleared → IDLE.
- WAIT_DONE: on tx_busy=0, clear gap counter to 0 → IDLE.
- Latency: entry available with sequencer idle → strobe at cycle 3 (READ=1, CAPTURE=2, LOAD=3) when no gap wait.
- enable deasserted mid-word: the current word completes through WAIT_DONE, then the block holds in IDLE.
- The FIFO is never read while in any non-IDLE state. fifo_rd_en is never asserted with fifo_empty=1.
- word_cnt holds its value after a message until the next csw load.

Optional Feature:
- Macro: TX_SEQ_STATS_EN.
- Defined: adds outputs words_sent[15:0] and errs_seen[15:0].
  - Both are saturating counters, cleared by reset.
  - words_sent increments on every tx_csw/tx_dw strobe.
  - errs_seen increments on every fmt_err or timeout_err pulse.
- Undefined: ports and counters absent; remaining behaviour identical.

Decomposition:
- Package tx_seq_pkg holds:
  - state enum;
  - field indices CSW_BIT=17, DW_BIT=16, DWORD_MSB=15;
  - entry width 18;
  - word_cnt width 6.
- One natural sub-module, seq_cycle_timer: saturating up-counter with clear and limit compare. Instantiated twice, once for the gap and once for the busy timeout.

Test Plan:
- Single csw 16'hA5A5 in FIFO, encoder model busy 40 cycles → fifo_rd_en one cycle, tx_csw one cycle at cycle 3, tx_dword=16'hA5A5, seq_active low after busy falls.
- csw 16'h1234 then dw 16'h0001, 16'h0002 back-to-back → dw strobes follow with no gap wait, word_cnt 1 then 2.
- Two csw entries back-to-back with GAP_CYCLES=8 → second tx_csw no earlier than 8 cycles after the first word's tx_busy fall.
- Entry 18'h0BEEF (csw=0, dw=0) → fmt_err one cycle, no strobe. Then csw + 33 dw words → 33rd dw dropped with fmt_err, word_cnt stays 32.
- Encoder model never asserts busy → timeout_err exactly 16 cycles after strobe, return to IDLE, next entry processed normally.
- Reset asserted during WAIT_BUSY → next cycle all outputs 0, state IDLE. After release, with FIFO nonempty, a fresh READ occurs.

Source files
------------

// File: rtl/tx_sequencer_1553_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tx_seq_pkg : shared types and field layout for the 1553 transmit sequencer |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package tx_seq_pkg;

    localparam int ENTRY_W   = 18;
    localparam int CSW_BIT   = 17;
    localparam int DW_BIT    = 16;
    localparam int DWORD_MSB = 15;
    localparam int WCNT_W    = 6;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ      = 3'd1,
        ST_CAPTURE   = 3'd2,
        ST_GAP_WAIT  = 3'd3,
        ST_LOAD      = 3'd4,
        ST_WAIT_BUSY = 3'd5,
        ST_WAIT_DONE = 3'd6
    } seq_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tx_sequencer_1553_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tx_sequencer_1553_if : FIFO/encoder bundle; stats under TX_SEQ_STATS_EN    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface tx_sequencer_1553_if;
    import tx_seq_pkg::*;

    logic                enable;
    logic                fifo_empty;
    logic [ENTRY_W-1:0]  fifo_do;
    logic                fifo_rd_en;
    logic                tx_busy;
    logic [15:0]         tx_dword;
    logic                tx_csw;
    logic                tx_dw;
    logic [WCNT_W-1:0]   word_cnt;
    logic                fmt_err;
    logic                timeout_err;
    logic                seq_active;
`ifdef TX_SEQ_STATS_EN
    logic [15:0]         words_sent;
    logic [15:0]         errs_seen;

    modport master (
        input  enable, fifo_empty, fifo_do, tx_busy,
        output fifo_rd_en, tx_dword, tx_csw, tx_dw, word_cnt,
               fmt_err, timeout_err, seq_active, words_sent, errs_seen
    );
    modport slave (
        output enable, fifo_empty, fifo_do, tx_busy,
        input  fifo_rd_en, tx_dword, tx_csw, tx_dw, word_cnt,
               fmt_err, timeout_err, seq_active, words_sent, errs_seen
    );
`else
    modport master (
        input  enable, fifo_empty, fifo_do, tx_busy,
        output fifo_rd_en, tx_dword, tx_csw, tx_dw, word_cnt,
               fmt_err, timeout_err, seq_active
    );
    modport slave (
        output enable, fifo_empty, fifo_do, tx_busy,
        input  fifo_rd_en, tx_dword, tx_csw, tx_dw, word_cnt,
               fmt_err, timeout_err, seq_active
    );
`endif

endinterface
`default_nettype wire

// File: rtl/tx_sequencer_1553_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_cycle_timer : saturating up-counter with clear and limit compare       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module seq_cycle_timer #(
    parameter int LIMIT   = 8,
    parameter int RST_VAL = 0,
    parameter bit EARLY   = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clr_i,
    input  wire logic inc_i,
    output logic      at_limit_o
);

    localparam int                CNT_W   = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0]  LIMIT_C = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0]  RST_C   = CNT_W'(RST_VAL);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q < LIMIT_C)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= RST_C;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // EARLY flags the cycle on whose closing edge the limit is reached.
    generate
        if (EARLY) begin : g_early
            assign at_limit_o = (cnt_d >= LIMIT_C);
        end else begin : g_late
            assign at_limit_o = (cnt_q >= LIMIT_C);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/tx_sequencer_1553.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tx_sequencer_1553 : pops FIFO entries and strobes them into the 1553       |
// | encoder with gap, word-count and busy-timeout policing.                    |
// | Optional macro TX_SEQ_STATS_EN adds words_sent / errs_seen counters.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tx_sequencer_1553
    import tx_seq_pkg::*;
#(
    parameter int GAP_CYCLES   = 8,
    parameter int BUSY_TIMEOUT = 16,
    parameter int MAX_DW       = 32
) (
    input  wire logic           enc_clk,
    input  wire logic           reset,
    tx_sequencer_1553_if.master bus
);

    localparam logic [WCNT_W-1:0] MAX_DW_C = WCNT_W'(MAX_DW);

    seq_state_t          state_q;
    seq_state_t          state_d;
    logic                is_csw_q;
    logic [15:0]         dword_q;
    logic [15:0]         tx_dword_q;
    logic [WCNT_W-1:0]   word_cnt_q;

    logic w_gap_done;
    logic w_tmo_done;
    logic w_gap_clr;
    logic w_tmo_clr;
    logic w_tmo_inc;
    logic w_csw_in;
    logic w_dw_in;
    logic w_dw_room;
    logic w_load_csw;
    logic w_load_enter;
    logic w_rd_en;
    logic w_csw_stb;
    logic w_dw_stb;
    logic w_fmt_err;
    logic w_tmo_err;
    logic w_active;

    assign w_csw_in   = bus.fifo_do[CSW_BIT];
    assign w_dw_in    = bus.fifo_do[DW_BIT];
    assign w_dw_room  = (word_cnt_q < MAX_DW_C);
    assign w_load_csw = (state_q == ST_CAPTURE) ? w_csw_in : is_csw_q;

    assign w_tmo_clr = (state_q == ST_LOAD);
    assign w_tmo_inc = (state_q == ST_WAIT_BUSY);
    // The gap is measured from the end of the previous word, or from a timeout.
    assign w_gap_clr = ((state_q == ST_WAIT_BUSY) && !bus.tx_busy && w_tmo_done) ||
                       ((state_q == ST_WAIT_DONE) && !bus.tx_busy);

    seq_cycle_timer #(
        .LIMIT   (GAP_CYCLES),
        .RST_VAL (GAP_CYCLES),
        .EARLY   (1'b0)
    ) u_gap_timer (
        .clk        (enc_clk),
        .rst        (reset),
        .clr_i      (w_gap_clr),
        .inc_i      (1'b1),
        .at_limit_o (w_gap_done)
    );

    seq_cycle_timer #(
        .LIMIT   (BUSY_TIMEOUT),
        .RST_VAL (0),
        .EARLY   (1'b1)
    ) u_busy_timer (
        .clk        (enc_clk),
        .rst        (reset),
        .clr_i      (w_tmo_clr),
        .inc_i      (w_tmo_inc),
        .at_limit_o (w_tmo_done)
    );

    always_ff @(posedge enc_clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.enable && !bus.fifo_empty && !bus.tx_busy) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (w_csw_in) begin
                    state_d = w_gap_done ? ST_LOAD : ST_GAP_WAIT;
                end else if (w_dw_in && w_dw_room) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP_WAIT: begin
                if (w_gap_done) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (w_tmo_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_rd_en      = 1'b0;
        w_csw_stb    = 1'b0;
        w_dw_stb     = 1'b0;
        w_fmt_err    = 1'b0;
        w_tmo_err    = 1'b0;
        w_load_enter = 1'b0;
        w_active     = (state_q != ST_IDLE);
        case (state_q)
            ST_READ: begin
                w_rd_en = 1'b1;
            end
            ST_CAPTURE: begin
                if (w_csw_in) begin
                    w_load_enter = w_gap_done;
                end else if (w_dw_in && w_dw_room) begin
                    w_load_enter = 1'b1;
                end else begin
                    w_fmt_err = 1'b1;
                end
            end
            ST_GAP_WAIT: begin
                w_load_enter = w_gap_done;
            end
            ST_LOAD: begin
                w_csw_stb = is_csw_q;
                w_dw_stb  = !is_csw_q;
            end
            ST_WAIT_BUSY: begin
                w_tmo_err = !bus.tx_busy && w_tmo_done;
            end
            default: begin
            end
        endcase
    end

    // tx_dword and word_cnt move on the edge into LOAD so they are valid with the strobe.
    always_ff @(posedge enc_clk) begin
        if (reset) begin
            is_csw_q   <= 1'b0;
            dword_q    <= '0;
            tx_dword_q <= '0;
            word_cnt_q <= '0;
        end else begin
            if (state_q == ST_CAPTURE) begin
                is_csw_q <= w_csw_in;
                dword_q  <= bus.fifo_do[DWORD_MSB:0];
            end
            if (w_load_enter) begin
                tx_dword_q <= (state_q == ST_CAPTURE) ? bus.fifo_do[DWORD_MSB:0] : dword_q;
                word_cnt_q <= w_load_csw ? '0 : word_cnt_q + 1'b1;
            end
        end
    end

    assign bus.fifo_rd_en  = w_rd_en;
    assign bus.tx_dword    = tx_dword_q;
    assign bus.tx_csw      = w_csw_stb;
    assign bus.tx_dw       = w_dw_stb;
    assign bus.word_cnt    = word_cnt_q;
    assign bus.fmt_err     = w_fmt_err;
    assign bus.timeout_err = w_tmo_err;
    assign bus.seq_active  = w_active;

`ifdef TX_SEQ_STATS_EN
    logic [15:0] words_sent_q;
    logic [15:0] errs_seen_q;

    always_ff @(posedge enc_clk) begin
        if (reset) begin
            words_sent_q <= '0;
            errs_seen_q  <= '0;
        end else begin
            if (w_csw_stb || w_dw_stb) begin
                words_sent_q <= sat_inc16(words_sent_q);
            end
            if (w_fmt_err || w_tmo_err) begin
                errs_seen_q <= sat_inc16(errs_seen_q);
            end
        end
    end

    assign bus.words_sent = words_sent_q;
    assign bus.errs_seen  = errs_seen_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tx_sequencer_1553.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_tx_sequencer_1553 : scoreboard bench with FIFO and encoder models       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_tx_sequencer_1553;

    localparam int K_CSW = 0;
    localparam int K_DW  = 1;
    localparam int K_FMT = 2;
    localparam int K_TMO = 3;

    typedef struct {
        int          kind;
        logic [15:0] data;
        logic [5:0]  wcnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tx_sequencer_1553_if bus();

    tx_sequencer_1553 #(
        .GAP_CYCLES   (8),
        .BUSY_TIMEOUT (16),
        .MAX_DW       (32)
    ) dut (
        .enc_clk (clk),
        .reset   (rst),
        .bus     (bus)
    );

    exp_t        sb[$];
    logic [17:0] fq[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int model_wcnt = 0;
    bit enc_respond = 1'b1;
    int busy_len  = 40;
    int busy_left = 0;
    int fall_cyc  = 0;
    bit fall_fresh = 1'b0;
    int last_stb_cyc = 0;
    bit lat_armed = 1'b0;
    int lat_cyc = 0;
    bit rd_armed = 1'b0;
    int rd_cyc = 0;
    bit prev_rd = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_ge(input string name, input int act, input int lo);
        total++;
        if (act < lo) begin
            bad++;
            $display("FAIL %s: got %0d want >= %0d (cycle %0d)", name, act, lo, cyc);
        end
    endtask

    task automatic push_exp(input int kind, input logic [15:0] data, input int wcnt);
        exp_t e;
        e.kind = kind;
        e.data = data;
        e.wcnt = 6'(wcnt);
        sb.push_back(e);
    endtask

    // Expected response per entry from a tiny word-count model.
    task automatic push_entry(input logic [17:0] ent);
        fq.push_back(ent);
        if (ent[17]) begin
            model_wcnt = 0;
            push_exp(K_CSW, ent[15:0], 0);
        end else if (ent[16] && model_wcnt < 32) begin
            model_wcnt++;
            push_exp(K_DW, ent[15:0], model_wcnt);
        end else begin
            push_exp(K_FMT, 16'h0, model_wcnt);
        end
    endtask

    function automatic logic [27:0] outs_vec();
        return {bus.fifo_rd_en, bus.tx_dword, bus.tx_csw, bus.tx_dw, bus.word_cnt,
                bus.fmt_err, bus.timeout_err, bus.seq_active};
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk);
            #1;
            done = (sb.size() == 0) && (fq.size() == 0) && !bus.tx_busy && !bus.seq_active;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s: not idle, got sb=%0d fifo=%0d busy=%0b active=%0b want all 0",
                     name, sb.size(), fq.size(), bus.tx_busy, bus.seq_active);
        end
    endtask

    // FIFO model, encoder model and output monitor, all on the falling edge.
    initial begin
        exp_t e;
        int   kind;
        bus.fifo_empty = 1'b1;
        bus.fifo_do    = '0;
        bus.tx_busy    = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.tx_csw || bus.tx_dw || bus.fmt_err || bus.timeout_err) begin
                    kind = bus.tx_csw ? K_CSW : bus.tx_dw ? K_DW : bus.fmt_err ? K_FMT : K_TMO;
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_event: got kind %0d want none", kind);
                    end else begin
                        e = sb.pop_front();
                        check("kind", kind, e.kind);
                        check("word_cnt", bus.word_cnt, e.wcnt);
                        if (kind <= K_DW) check("tx_dword", bus.tx_dword, e.data);
                    end
                    if (kind <= K_DW) begin
                        if (lat_armed) begin
                            check("strobe_latency", cyc, lat_cyc);
                            lat_armed = 1'b0;
                        end
                        if (fall_fresh && kind == K_DW) check("dw_no_gap", cyc - fall_cyc, 4);
                        if (fall_fresh && kind == K_CSW) check_ge("csw_gap", cyc - fall_cyc, 8);
                        fall_fresh   = 1'b0;
                        last_stb_cyc = cyc;
                    end
                    if (kind == K_TMO) check("timeout_delay", cyc - last_stb_cyc, 16);
                end
                if (bus.fifo_rd_en) begin
                    check("rd_not_empty", bus.fifo_empty, 1'b0);
                    check("rd_single_cycle", prev_rd, 1'b0);
                    if (rd_armed) begin
                        check("rd_cycle", cyc, rd_cyc);
                        rd_armed = 1'b0;
                    end
                    if (fq.size() > 0) bus.fifo_do = fq.pop_front();
                end
                if ((bus.tx_csw || bus.tx_dw) && enc_respond) begin
                    bus.tx_busy = 1'b1;
                    busy_left   = busy_len;
                end else if (busy_left > 0) begin
                    busy_left--;
                    if (busy_left == 0) begin
                        bus.tx_busy = 1'b0;
                        fall_cyc    = cyc;
                        fall_fresh  = 1'b1;
                    end
                end
            end
            prev_rd = bus.fifo_rd_en;
            bus.fifo_empty = (fq.size() == 0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.enable = 1'b0;
        rst = 1'b1;
        step(3);
        @(negedge clk);
        check("reset_outputs", outs_vec(), 28'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.enable = 1'b1;
        step(2);

        // Single csw with a long busy; first csw after reset is not delayed.
        busy_len = 40;
        push_entry({2'b10, 16'hA5A5});
        rd_armed  = 1'b1;
        rd_cyc    = cyc + 1;
        lat_armed = 1'b1;
        lat_cyc   = cyc + 3;
        wait_idle("single_csw", 200);

        busy_len = 5;
        push_entry({2'b10, 16'h1234});
        push_entry({2'b01, 16'h0001});
        push_entry({2'b01, 16'h0002});
        wait_idle("csw_dw_dw", 200);

        push_entry({2'b10, 16'h1111});
        push_entry({2'b11, 16'h2222});
        wait_idle("csw_csw_gap", 200);

        busy_len = 2;
        push_entry(18'h0BEEF);
        push_entry({2'b10, 16'h0C00});
        for (int k = 1; k <= 33; k++) push_entry({2'b01, 16'(k)});
        wait_idle("dw_overflow", 3000);
        check("word_cnt_held", bus.word_cnt, 6'd32);

        enc_respond = 1'b0;
        push_entry({2'b10, 16'h0F0F});
        push_exp(K_TMO, 16'h0, 0);
        wait_idle("timeout", 200);
        enc_respond = 1'b1;
        push_entry({2'b01, 16'h0DD1});
        wait_idle("after_timeout", 200);

        // Reset while parked in WAIT_BUSY with a second entry waiting.
        enc_respond = 1'b0;
        push_entry({2'b10, 16'hC0DE});
        for (int i = 0; i < 60 && sb.size() != 0; i++) step(1);
        check("c0de_strobed", sb.size(), 0);
        step(3);
        push_entry({2'b10, 16'h5A5A});
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midop_reset_outputs", outs_vec(), 28'h0);
        enc_respond = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd_armed = 1'b1;
        rd_cyc   = cyc + 1;
        wait_idle("after_reset", 200);
        check("rd_after_reset_seen", rd_armed, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
